// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a controller (master) and the subtractor (slave).
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor_unit.sv
// Single-bit full subtractor cell, time-shared across all bit positions.
module full_subtractor_unit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of x - y - bin.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit per edge through the shared full-subtractor cell
//   DONE  | one-cycle done pulse, diff/borrow_out freshly loaded
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  full_subtractor_unit u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result fills from the MSB side so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    res_next = {cell_d, res_sr[WIDTH-1:1]};
  end

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      a_sr           <= '0;
      b_sr           <= '0;
      res_sr         <= '0;
      borrow         <= 1'b0;
      cnt            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            res_sr   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= cell_bout;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // Outputs only move here, so they stay stable for the whole run.
            bus.diff       <= res_next;
            bus.borrow_out <= cell_bout;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not sampled here; a new request waits for IDLE.
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
